// File: rtl/comp_8bit.sv
// Byte-wise run-length compressor: packs runs of equal bytes into 16-bit {run_len, byte} tokens, 16 per 256-bit beat.
// Latency: one byte per cycle after the accept cycle; a beat appears two cycles after its last token is written.
// Backpressure: input ready only in IDLE; SCAN/FLUSH freeze when a token cannot land because the packer is full and the output is held.
module comp_8bit (
  input  logic         axis_aclk,
  input  logic         axis_areset,
  input  logic [255:0] axis_tdata,
  input  logic [31:0]  axis_tkeep,
  input  logic         axis_tlast,
  input  logic         axis_tvalid,
  output logic         axis_tready,
  output logic [255:0] axis_tdata_c2s,
  output logic [31:0]  axis_tkeep_c2s,
  output logic         axis_tlast_c2s,
  output logic         axis_tvalid_c2s,
  input  logic         axis_tready_c2s
);

  typedef enum logic [1:0] {IDLE, SCAN, FLUSH} state_t;

  state_t       state, state_nxt;

  // Latched input beat
  logic [255:0] beat_dat;
  logic [5:0]   nbytes;
  logic         beat_last;
  logic [4:0]   idx;

  // Current run
  logic [7:0]   cur_byte, cur_nxt;
  logic [7:0]   run_cnt, run_nxt;

  // Token packer
  logic [255:0] packer;
  logic [4:0]   tok_cnt;
  logic         flush_req;

  // Per-cycle decisions
  logic [5:0]   keep_cnt;
  logic [7:0]   scan_byte;
  logic         tok_need;
  logic         tok_wr;
  logic         stall;
  logic         flush_set;
  logic         xfer;
  logic [15:0]  tok_dat;
  logic [31:0]  xfer_keep;

  // Input is only taken while idle; held off during reset.
  assign axis_tready = (state == IDLE) && !axis_areset;

  // The packer moves out when full or flushing, provided the output slot is free or draining.
  assign xfer = ((tok_cnt == 5'd16) || flush_req) && (!axis_tvalid_c2s || axis_tready_c2s);

  // Count valid bytes in the incoming beat and build the keep mask for the beat being transferred.
  always_comb begin
    keep_cnt  = '0;
    xfer_keep = '0;
    for (int i = 0; i < 32; i++) begin
      keep_cnt = keep_cnt + 6'(axis_tkeep[i]);
    end
    for (int k = 0; k < 16; k++) begin
      if (5'(k) < tok_cnt) begin
        xfer_keep[2*k +: 2] = 2'b11;
      end
    end
  end

  // Next-state, run tracking and token-write decisions.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur_byte;
    run_nxt   = run_cnt;
    scan_byte = beat_dat[{idx, 3'b000} +: 8];
    tok_dat   = {run_cnt, cur_byte};
    tok_need  = 1'b0;
    stall     = 1'b0;
    flush_set = 1'b0;
    case (state)
      IDLE: begin
        if (axis_tvalid) begin
          if (keep_cnt != 6'd0) begin
            state_nxt = SCAN;
          end else if (axis_tlast) begin
            state_nxt = FLUSH;
          end
        end
      end
      SCAN: begin
        // A byte that does not extend the current run closes it out as a token.
        tok_need = (run_cnt != 8'd0) && !((scan_byte == cur_byte) && (run_cnt != 8'd255));
        stall    = tok_need && (tok_cnt == 5'd16) && !xfer;
        if (!stall) begin
          if (tok_need || (run_cnt == 8'd0)) begin
            cur_nxt = scan_byte;
            run_nxt = 8'd1;
          end else begin
            run_nxt = run_cnt + 8'd1;
          end
          if ({1'b0, idx} == (nbytes - 6'd1)) begin
            state_nxt = beat_last ? FLUSH : IDLE;
          end
        end
      end
      FLUSH: begin
        if (!flush_req) begin
          // First FLUSH cycle: emit whatever run is pending, then request the final beat.
          tok_need = (run_cnt != 8'd0);
          stall    = tok_need && (tok_cnt == 5'd16) && !xfer;
          if (!stall) begin
            flush_set = 1'b1;
            run_nxt   = 8'd0;
          end
        end else if (xfer) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    tok_wr = tok_need && !stall;
  end

  // State, input beat capture, run registers and packer.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      state     <= IDLE;
      beat_dat  <= '0;
      nbytes    <= '0;
      beat_last <= 1'b0;
      idx       <= '0;
      cur_byte  <= '0;
      run_cnt   <= '0;
      packer    <= '0;
      tok_cnt   <= '0;
      flush_req <= 1'b0;
    end else begin
      state    <= state_nxt;
      cur_byte <= cur_nxt;
      run_cnt  <= run_nxt;

      if ((state == IDLE) && axis_tvalid) begin
        beat_dat  <= axis_tdata;
        nbytes    <= keep_cnt;
        beat_last <= axis_tlast;
        idx       <= '0;
      end else if ((state == SCAN) && !stall) begin
        idx <= idx + 5'd1;
      end

      // A token written alongside a transfer starts the freshly cleared packer.
      if (xfer) begin
        packer    <= tok_wr ? {240'b0, tok_dat} : 256'b0;
        tok_cnt   <= tok_wr ? 5'd1 : 5'd0;
        flush_req <= flush_set;
      end else begin
        if (tok_wr) begin
          packer[{tok_cnt[3:0], 4'b0000} +: 16] <= tok_dat;
          tok_cnt <= tok_cnt + 5'd1;
        end
        if (flush_set) begin
          flush_req <= 1'b1;
        end
      end
    end
  end

  // Output beat register: loads on transfer, holds while stalled, drops valid once accepted.
  always_ff @(posedge axis_aclk) begin
    if (axis_areset) begin
      axis_tdata_c2s  <= '0;
      axis_tkeep_c2s  <= '0;
      axis_tlast_c2s  <= 1'b0;
      axis_tvalid_c2s <= 1'b0;
    end else if (xfer) begin
      axis_tdata_c2s  <= packer;
      axis_tkeep_c2s  <= xfer_keep;
      axis_tlast_c2s  <= flush_req;
      axis_tvalid_c2s <= 1'b1;
    end else if (axis_tready_c2s) begin
      axis_tvalid_c2s <= 1'b0;
    end
  end

endmodule
